// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - fetch, register-file, writeback and execute signals of the decode stage
interface decode_stage_if #(
  parameter int XLEN = 32
);
  logic            if_valid;
  logic            if_ready;
  logic [31:0]     if_instr;
  logic [XLEN-1:0] if_pc;
  logic [4:0]      rf_read_addr1;
  logic [4:0]      rf_read_addr2;
  logic [31:0]     rf_read_data1;
  logic [31:0]     rf_read_data2;
  logic            wb_write_en;
  logic [4:0]      wb_write_addr;
  logic [31:0]     wb_write_data;
  logic            flush;
  logic            ex_valid;
  logic            ex_ready;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_rs_data;
  logic [XLEN-1:0] ex_rt_data;
  logic [XLEN-1:0] ex_imm;
  logic [4:0]      ex_rs;
  logic [4:0]      ex_rt;
  logic [4:0]      ex_dest;
  logic [2:0]      ex_alu_op;
  logic            ex_alu_src_imm;
  logic            ex_mem_read;
  logic            ex_mem_write;
  logic            ex_reg_write;
  logic            ex_branch;
  logic            ex_jump;
  logic            ex_illegal;
  logic [XLEN-1:0] ex_jump_target;

  modport slave (
    input  if_valid, if_instr, if_pc, rf_read_data1, rf_read_data2,
           wb_write_en, wb_write_addr, wb_write_data, flush, ex_ready,
    output if_ready, rf_read_addr1, rf_read_addr2, ex_valid, ex_pc, ex_rs_data,
           ex_rt_data, ex_imm, ex_rs, ex_rt, ex_dest, ex_alu_op, ex_alu_src_imm,
           ex_mem_read, ex_mem_write, ex_reg_write, ex_branch, ex_jump,
           ex_illegal, ex_jump_target
  );

  modport master (
    output if_valid, if_instr, if_pc, rf_read_data1, rf_read_data2,
           wb_write_en, wb_write_addr, wb_write_data, flush, ex_ready,
    input  if_ready, rf_read_addr1, rf_read_addr2, ex_valid, ex_pc, ex_rs_data,
           ex_rt_data, ex_imm, ex_rs, ex_rt, ex_dest, ex_alu_op, ex_alu_src_imm,
           ex_mem_read, ex_mem_write, ex_reg_write, ex_branch, ex_jump,
           ex_illegal, ex_jump_target
  );
endinterface

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - MIPS decode stage: IF/ID register, decode, writeback bypass, load-use stall, ID/EX register
module decode_stage #(
  parameter int XLEN = 32
) (
  input logic           clock,
  input logic           reset,
  decode_stage_if.slave bus
);
  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_t;

  logic            id_valid;
  logic [31:0]     id_instr;
  logic [XLEN-1:0] id_pc;

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;
  assign op    = id_instr[31:26];
  assign rs    = id_instr[25:21];
  assign rt    = id_instr[20:16];
  assign rd    = id_instr[15:11];
  assign funct = id_instr[5:0];

  assign bus.rf_read_addr1 = rs;
  assign bus.rf_read_addr2 = rt;

  alu_op_t    alu_op;
  logic       alu_src_imm;
  logic       mem_read;
  logic       mem_write;
  logic       writes_reg;
  logic       branch;
  logic       jump;
  logic       illegal;
  logic       uses_rt;
  logic [4:0] dest_raw;
  logic       reg_write;
  logic [4:0] dest;

  always_comb begin
    alu_op      = ALU_ADD;
    alu_src_imm = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    writes_reg  = 1'b0;
    branch      = 1'b0;
    jump        = 1'b0;
    illegal     = 1'b0;
    uses_rt     = 1'b0;
    dest_raw    = rt;
    case (op)
      6'h00: begin
        uses_rt    = 1'b1;
        dest_raw   = rd;
        writes_reg = 1'b1;
        case (funct)
          6'h20:   alu_op = ALU_ADD;
          6'h22:   alu_op = ALU_SUB;
          6'h24:   alu_op = ALU_AND;
          6'h25:   alu_op = ALU_OR;
          6'h2A:   alu_op = ALU_SLT;
          default: begin
            writes_reg = 1'b0;
            illegal    = 1'b1;
          end
        endcase
      end
      6'h08: begin
        alu_src_imm = 1'b1;
        writes_reg  = 1'b1;
      end
      6'h23: begin
        alu_src_imm = 1'b1;
        mem_read    = 1'b1;
        writes_reg  = 1'b1;
      end
      6'h2B: begin
        alu_src_imm = 1'b1;
        mem_write   = 1'b1;
        uses_rt     = 1'b1;
      end
      6'h04: begin
        alu_op  = ALU_SUB;
        branch  = 1'b1;
        uses_rt = 1'b1;
      end
      6'h02:   jump = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

  // A write to $0 is architecturally a no-op, so it carries neither reg_write nor a destination.
  assign reg_write = writes_reg && (dest_raw != 5'd0);
  assign dest      = reg_write ? dest_raw : 5'd0;

  function automatic logic [31:0] select_operand(input logic [4:0] addr, input logic [31:0] rf_data,
                                                 input logic wb_en, input logic [4:0] wb_addr,
                                                 input logic [31:0] wb_data);
    if (addr == 5'd0)                   return 32'd0;
    else if (wb_en && (wb_addr == addr)) return wb_data;
    else                                 return rf_data;
  endfunction

  logic [31:0] rs_data;
  logic [31:0] rt_data;
  assign rs_data = select_operand(rs, bus.rf_read_data1, bus.wb_write_en, bus.wb_write_addr, bus.wb_write_data);
  assign rt_data = select_operand(rt, bus.rf_read_data2, bus.wb_write_en, bus.wb_write_addr, bus.wb_write_data);

  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] jump_target;
  assign imm         = {{(XLEN-16){id_instr[15]}}, id_instr[15:0]};
  assign pc_plus4    = id_pc + XLEN'(4);
  assign jump_target = (pc_plus4 & {{(XLEN-28){1'b1}}, 28'h0}) | XLEN'({id_instr[25:0], 2'b00});

  logic ex_free;
  logic hazard;
  logic advance;
  assign ex_free = !bus.ex_valid || bus.ex_ready;
  assign hazard  = bus.ex_valid && bus.ex_mem_read && (bus.ex_dest != 5'd0) &&
                   ((bus.ex_dest == rs) || (uses_rt && (bus.ex_dest == rt)));
  assign advance = id_valid && ex_free && !hazard && !bus.flush;
  assign bus.if_ready = !reset && !bus.flush && (!id_valid || advance);

  always_ff @(posedge clock) begin
    if (reset) begin
      id_valid <= 1'b0;
      id_instr <= '0;
      id_pc    <= '0;
    end else if (bus.flush) begin
      id_valid <= 1'b0;
    end else if (bus.if_valid && bus.if_ready) begin
      id_valid <= 1'b1;
      id_instr <= bus.if_instr;
      id_pc    <= bus.if_pc;
    end else if (advance) begin
      id_valid <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bus.ex_valid       <= 1'b0;
      bus.ex_pc          <= '0;
      bus.ex_rs_data     <= '0;
      bus.ex_rt_data     <= '0;
      bus.ex_imm         <= '0;
      bus.ex_rs          <= '0;
      bus.ex_rt          <= '0;
      bus.ex_dest        <= '0;
      bus.ex_alu_op      <= '0;
      bus.ex_alu_src_imm <= 1'b0;
      bus.ex_mem_read    <= 1'b0;
      bus.ex_mem_write   <= 1'b0;
      bus.ex_reg_write   <= 1'b0;
      bus.ex_branch      <= 1'b0;
      bus.ex_jump        <= 1'b0;
      bus.ex_illegal     <= 1'b0;
      bus.ex_jump_target <= '0;
    end else if (bus.flush) begin
      bus.ex_valid <= 1'b0;
    end else if (advance) begin
      bus.ex_valid       <= 1'b1;
      bus.ex_pc          <= id_pc;
      bus.ex_rs_data     <= XLEN'(rs_data);
      bus.ex_rt_data     <= XLEN'(rt_data);
      bus.ex_imm         <= imm;
      bus.ex_rs          <= rs;
      bus.ex_rt          <= rt;
      bus.ex_dest        <= dest;
      bus.ex_alu_op      <= alu_op;
      bus.ex_alu_src_imm <= alu_src_imm;
      bus.ex_mem_read    <= mem_read;
      bus.ex_mem_write   <= mem_write;
      bus.ex_reg_write   <= reg_write;
      bus.ex_branch      <= branch;
      bus.ex_jump        <= jump;
      bus.ex_illegal     <= illegal;
      bus.ex_jump_target <= jump_target;
    end else if (ex_free) begin
      // Nothing to hand over (empty, stalled on a load-use, or drained): insert a bubble.
      bus.ex_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed scoreboard bench for decode_stage
module tb_decode_stage;
  localparam logic [6:0] F_IMM = 7'b1000000;
  localparam logic [6:0] F_MR  = 7'b0100000;
  localparam logic [6:0] F_MW  = 7'b0010000;
  localparam logic [6:0] F_RW  = 7'b0001000;
  localparam logic [6:0] F_BR  = 7'b0000100;
  localparam logic [6:0] F_J   = 7'b0000010;
  localparam logic [6:0] F_ILL = 7'b0000001;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] rsd;
    logic [31:0] rtd;
    logic [31:0] imm;
    logic [31:0] jt;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    logic [2:0]  alu;
    logic [6:0]  flags;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic [31:0] rf [32];

  decode_stage_if #(.XLEN(32)) bus ();
  decode_stage #(.XLEN(32)) dut (.clock(clock), .reset(reset), .bus(bus.slave));

  always #5 clock = ~clock;

  assign bus.rf_read_data1 = rf[bus.rf_read_addr1];
  assign bus.rf_read_data2 = rf[bus.rf_read_addr2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] rsd,
                       input logic [31:0] rtd, input logic [4:0] dest, input logic [2:0] alu,
                       input logic [6:0] flags);
    exp_t e;
    logic [31:0] pc4;
    logic accepted;
    pc4 = pc + 32'd4;
    e.pc = pc; e.rsd = rsd; e.rtd = rtd; e.dest = dest; e.alu = alu; e.flags = flags;
    e.rs = instr[25:21];
    e.rt = instr[20:16];
    e.imm = {{16{instr[15]}}, instr[15:0]};
    e.jt = {pc4[31:28], instr[25:0], 2'b00};
    sb.push_back(e);
    bus.if_valid = 1'b1;
    bus.if_instr = instr;
    bus.if_pc    = pc;
    accepted = 1'b0;
    for (int n = 0; n < 20 && !accepted; n++) begin
      @(negedge clock);
      accepted = bus.if_ready;
      tick();
    end
    bus.if_valid = 1'b0;
    if (!accepted) chk("issue_timeout", accepted, 1);
  endtask

  // Scoreboard: each instruction consumed by execute is compared with its queued expectation.
  always @(negedge clock) begin
    if (!reset && bus.ex_valid && bus.ex_ready) begin
      chk("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("ex_pc", bus.ex_pc, mon_e.pc);
        chk("ex_rs_data", bus.ex_rs_data, mon_e.rsd);
        chk("ex_rt_data", bus.ex_rt_data, mon_e.rtd);
        chk("ex_imm", bus.ex_imm, mon_e.imm);
        chk("ex_rs", bus.ex_rs, mon_e.rs);
        chk("ex_rt", bus.ex_rt, mon_e.rt);
        chk("ex_dest", bus.ex_dest, mon_e.dest);
        chk("ex_alu_op", bus.ex_alu_op, mon_e.alu);
        chk("ex_flags", {bus.ex_alu_src_imm, bus.ex_mem_read, bus.ex_mem_write, bus.ex_reg_write,
                         bus.ex_branch, bus.ex_jump, bus.ex_illegal}, mon_e.flags);
        if (bus.ex_jump) chk("ex_jump_target", bus.ex_jump_target, mon_e.jt);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'(i + 100);
    rf[0] = 32'h55;
    rf[1] = 32'd5;
    rf[2] = 32'd7;
    bus.if_valid = 1'b1;
    bus.if_instr = 32'h00221820;
    bus.if_pc = 32'h0;
    bus.wb_write_en = 1'b0;
    bus.wb_write_addr = 5'd0;
    bus.wb_write_data = 32'd0;
    bus.flush = 1'b0;
    bus.ex_ready = 1'b1;

    // Reset held two cycles with a fetch offered
    tick();
    tick();
    chk("rst_if_ready", bus.if_ready, 0);
    chk("rst_ex_valid", bus.ex_valid, 0);
    chk("rst_ex_dest", bus.ex_dest, 0);
    chk("rst_ex_reg_write", bus.ex_reg_write, 0);
    reset = 1'b0;
    bus.if_valid = 1'b0;
    #1;
    chk("rel_if_ready", bus.if_ready, 1);

    // add $3,$1,$2 and its latency
    issue(32'h00221820, 32'h100, 32'd5, 32'd7, 5'd3, 3'd0, F_RW);
    chk("lat_ex_valid_n", bus.ex_valid, 0);
    tick();
    chk("lat_ex_valid_n1", bus.ex_valid, 1);

    // lw then dependent add: exactly one bubble
    issue(32'h8C220004, 32'h104, 32'd5, 32'd7, 5'd2, 3'd0, F_IMM | F_MR | F_RW);
    issue(32'h00421820, 32'h108, 32'd7, 32'd7, 5'd3, 3'd0, F_RW);
    chk("lu_lw_valid", bus.ex_valid, 1);
    tick();
    chk("lu_bubble", bus.ex_valid, 0);
    tick();
    chk("lu_add_valid", bus.ex_valid, 1);

    // Writeback bypass, and a write to $0 never bypasses
    issue(32'h00221820, 32'h10C, 32'hDEAD, 32'd7, 5'd3, 3'd0, F_RW);
    bus.wb_write_en = 1'b1; bus.wb_write_addr = 5'd1; bus.wb_write_data = 32'hDEAD;
    tick();
    bus.wb_write_en = 1'b0;
    issue(32'h00021820, 32'h110, 32'd0, 32'd7, 5'd3, 3'd0, F_RW);
    bus.wb_write_en = 1'b1; bus.wb_write_addr = 5'd0; bus.wb_write_data = 32'h1234;
    tick();
    bus.wb_write_en = 1'b0;

    // Execute stall with both stages full, then flush
    issue(32'h00222025, 32'h114, 32'd5, 32'd7, 5'd4, 3'd3, F_RW);
    bus.ex_ready = 1'b0;
    issue(32'h00222824, 32'h118, 32'd5, 32'd7, 5'd5, 3'd2, F_RW);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_valid", bus.ex_valid, 1);
      chk("stall_pc", bus.ex_pc, 32'h114);
      chk("stall_rs_data", bus.ex_rs_data, 32'd5);
      chk("stall_dest", bus.ex_dest, 5'd4);
      chk("stall_alu_op", bus.ex_alu_op, 3'd3);
      chk("stall_if_ready", bus.if_ready, 0);
    end
    bus.if_valid = 1'b1;
    bus.if_instr = 32'h00221820;
    bus.if_pc = 32'h11C;
    bus.flush = 1'b1;
    #1;
    chk("flush_if_ready", bus.if_ready, 0);
    tick();
    bus.flush = 1'b0;
    bus.if_valid = 1'b0;
    bus.ex_ready = 1'b1;
    void'(sb.pop_front());
    void'(sb.pop_front());
    #1;
    chk("flush_ex_valid", bus.ex_valid, 0);
    chk("flush_if_ready_after", bus.if_ready, 1);
    tick();
    chk("flush_no_accept", bus.ex_valid, 0);

    // Illegal opcode flows as a NOP; the next instruction is unaffected
    issue(32'hFC000000, 32'h120, 32'd0, 32'd0, 5'd0, 3'd0, F_ILL);
    issue(32'h00223022, 32'h124, 32'd5, 32'd7, 5'd6, 3'd1, F_RW);

    // Remaining decode table
    issue(32'h0022382A, 32'h128, 32'd5, 32'd7, 5'd7, 3'd4, F_RW);
    issue(32'h2028FFFF, 32'h12C, 32'd5, 32'd108, 5'd8, 3'd0, F_IMM | F_RW);
    issue(32'h20000005, 32'h130, 32'd0, 32'd0, 5'd0, 3'd0, F_IMM);
    issue(32'hAC220008, 32'h134, 32'd5, 32'd7, 5'd0, 3'd0, F_IMM | F_MW);
    issue(32'h10220003, 32'h138, 32'd5, 32'd7, 5'd0, 3'd1, F_BR);
    issue(32'h08000010, 32'h10000040, 32'd0, 32'd0, 5'd0, 3'd0, F_J);

    for (int n = 0; n < 20 && sb.size() != 0; n++) tick();
    chk("sb_drain", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
